// File: rtl/dpi_stream_sequencer_if.sv
// dpi_stream_sequencer_if
// Byte-wide packet stream feeding the DPI stream sequencer.
//   in_data : packet byte
//   in_sop  : first byte of packet (qualified by in_vld)
//   in_eop  : last byte of packet (qualified by in_vld)
//   in_vld  : byte valid
//   in_rdy  : sink ready; a byte transfers when in_vld & in_rdy
// master = packet source, slave = sequencer.
interface dpi_stream_sequencer_if;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic       in_vld;
    logic       in_rdy;

    modport master (output in_data, in_sop, in_eop, in_vld, input in_rdy);
    modport slave  (input in_data, in_sop, in_eop, in_vld, output in_rdy);
endinterface

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer
// Front-end of the per-regex matcher wrappers. Builds a flow key from the first
// KEY_BYTES header bytes (big-endian, zero-extended), maps it to a 6-bit stream
// id through a 64-entry direct-mapped tag table, then drives the matcher
// control sequence load_state -> payload chars -> eop.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_s              byte stream (slave side of dpi_stream_sequencer_if)
//   cfg_enable_i      global matcher enable, latched at SOP
//   char_in_o/_vld_o  registered payload byte to the matchers
//   stream_id_o       table index of the current packet
//   new_stream_id_o   key missed the table
//   load_state_o      one-cycle pulse at packet start
//   eop_o             one-cycle pulse after the drain window
//   enable_o          latched cfg_enable
//   busy_o            sequencer not idle
//   runt_drop_o       one-cycle pulse when a header-only packet is dropped
//
// Optional build macro DPI_STATS_EN adds wrapping counters
//   stat_pkts_o, stat_new_o, stat_runt_o.
//
// state   | meaning
// IDLE    | waiting for an SOP byte; non-SOP bytes are discarded
// HDR     | collecting remaining key bytes
// LOOKUP  | tag table compare and fill on miss
// LOAD    | load_state pulse
// GAP     | LOAD_GAP cycles of matcher state restore
// PAYLOAD | forwarding payload bytes
// DRAIN   | EOP_DRAIN cycles of matcher pipeline flush
// EOP     | eop pulse
module dpi_stream_sequencer #(
    parameter int KEY_BYTES = 4,
    parameter int LOAD_GAP  = 2,
    parameter int EOP_DRAIN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpi_stream_sequencer_if.slave in_s,
    input  logic                  cfg_enable_i,
    output logic [7:0]            char_in_o,
    output logic                  char_in_vld_o,
    output logic [5:0]            stream_id_o,
    output logic                  new_stream_id_o,
    output logic                  load_state_o,
    output logic                  eop_o,
    output logic                  enable_o,
    output logic                  busy_o,
    output logic                  runt_drop_o
`ifdef DPI_STATS_EN
   ,output logic [31:0]           stat_pkts_o,
    output logic [31:0]           stat_new_o,
    output logic [15:0]           stat_runt_o
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_LOOKUP  = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
    localparam logic [2:0] S_EOP     = 3'd7;

    localparam int CW = 16;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   key_q, key_d;
    logic          enable_q, enable_d;
    logic [5:0]    sid_q, sid_d;
    logic          new_q, new_d;
    logic [7:0]    char_q, char_d;
    logic          char_vld_q, char_vld_d;
    logic          runt_q, runt_d;

    logic [63:0]   valid_q;
    logic [31:0]   tag_q [64];

    logic [5:0]    idx;
    logic          hit;
    logic          tag_we;
    logic          in_rdy;
    logic          acc;

    assign idx = key_q[5:0] ^ key_q[11:6] ^ key_q[17:12] ^ key_q[23:18]
               ^ key_q[29:24] ^ {4'b0, key_q[31:30]};
    assign hit = valid_q[idx] && (tag_q[idx] == key_q);

    assign in_rdy      = (state_q == S_IDLE) || (state_q == S_HDR) || (state_q == S_PAYLOAD);
    assign in_s.in_rdy = in_rdy;
    assign acc         = in_s.in_vld && in_rdy;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        enable_d   = enable_q;
        sid_d      = sid_q;
        new_d      = new_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        runt_d     = 1'b0;
        tag_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc && in_s.in_sop) begin
                    key_d    = {24'b0, in_s.in_data};
                    enable_d = cfg_enable_i;
                    // Any eop inside the header, even on the SOP byte, is a runt.
                    if (in_s.in_eop) begin
                        runt_d = 1'b1;
                    end else if (KEY_BYTES > 1) begin
                        state_d = S_HDR;
                        cnt_d   = CW'(KEY_BYTES - 1);
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_HDR: begin
                if (acc) begin
                    key_d = {key_q[23:0], in_s.in_data};
                    if (in_s.in_eop) begin
                        runt_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_q == CW'(1)) begin
                        state_d = S_LOOKUP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_LOOKUP: begin
                sid_d   = idx;
                new_d   = !hit;
                tag_we  = !hit;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (LOAD_GAP == 0) begin
                    state_d = S_PAYLOAD;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = CW'(LOAD_GAP - 1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_PAYLOAD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_PAYLOAD: begin
                // in_sop here is just another payload byte.
                if (acc) begin
                    char_d     = in_s.in_data;
                    char_vld_d = 1'b1;
                    if (in_s.in_eop) begin
                        // The drain window starts on the cycle the last char is visible.
                        if (EOP_DRAIN == 0) begin
                            state_d = S_EOP;
                        end else begin
                            state_d = S_DRAIN;
                            cnt_d   = CW'(EOP_DRAIN - 1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_EOP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_EOP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_q      <= '0;
            enable_q   <= 1'b0;
            sid_q      <= '0;
            new_q      <= 1'b0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
            runt_q     <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            enable_q   <= enable_d;
            sid_q      <= sid_d;
            new_q      <= new_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
            runt_q     <= runt_d;
            if (tag_we) valid_q[idx] <= 1'b1;
        end
    end

    // Tags need no reset: a tag is only trusted behind its valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && tag_we) tag_q[idx] <= key_q;
    end

    assign char_in_o       = char_q;
    assign char_in_vld_o   = char_vld_q;
    assign stream_id_o     = sid_q;
    assign new_stream_id_o = new_q;
    assign enable_o        = enable_q;
    assign runt_drop_o     = runt_q;
    assign load_state_o    = (state_q == S_LOAD);
    assign eop_o           = (state_q == S_EOP);
    assign busy_o          = (state_q != S_IDLE);

`ifdef DPI_STATS_EN
    logic [31:0] stat_pkts_q, stat_new_q;
    logic [15:0] stat_runt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkts_q <= '0;
            stat_new_q  <= '0;
            stat_runt_q <= '0;
        end else begin
            if (state_q == S_EOP)          stat_pkts_q <= stat_pkts_q + 32'd1;
            if (state_q == S_EOP && new_q) stat_new_q  <= stat_new_q + 32'd1;
            if (runt_q)                    stat_runt_q <= stat_runt_q + 16'd1;
        end
    end

    assign stat_pkts_o = stat_pkts_q;
    assign stat_new_o  = stat_new_q;
    assign stat_runt_o = stat_runt_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Bench for dpi_stream_sequencer. Each packet is planned up front: the input
// drive per cycle and the expected outputs per cycle are derived from the
// sequencing rules (header length, lookup/load/gap/drain lengths) and a simple
// key->index table model. A compare process checks every cycle.
module tb_dpi_stream_sequencer;
    localparam int KB   = 4;
    localparam int LG   = 2;
    localparam int ED   = 4;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_enable = 1'b0;

    logic [7:0] char_in;
    logic       char_in_vld, new_stream_id, load_state, eop, enable, busy, runt_drop;
    logic [5:0] stream_id;
`ifdef DPI_STATS_EN
    logic [31:0] stat_pkts, stat_new;
    logic [15:0] stat_runt;
`endif

    dpi_stream_sequencer_if sif();

    dpi_stream_sequencer #(.KEY_BYTES(KB), .LOAD_GAP(LG), .EOP_DRAIN(ED)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_s            (sif),
        .cfg_enable_i    (cfg_enable),
        .char_in_o       (char_in),
        .char_in_vld_o   (char_in_vld),
        .stream_id_o     (stream_id),
        .new_stream_id_o (new_stream_id),
        .load_state_o    (load_state),
        .eop_o           (eop),
        .enable_o        (enable),
        .busy_o          (busy),
        .runt_drop_o     (runt_drop)
`ifdef DPI_STATS_EN
       ,.stat_pkts_o     (stat_pkts),
        .stat_new_o      (stat_new),
        .stat_runt_o     (stat_runt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // per-cycle stimulus plan
    bit       drv_rst [MAXC];
    bit       drv_vld [MAXC];
    bit       drv_sop [MAXC];
    bit       drv_eop [MAXC];
    bit       drv_en  [MAXC];
    bit [7:0] drv_dat [MAXC];

    // per-cycle expected outputs
    bit       e_load [MAXC];
    bit       e_eop  [MAXC];
    bit       e_runt [MAXC];
    bit       e_cv   [MAXC];
    bit [7:0] e_char [MAXC];
    bit       e_busy [MAXC];
    bit       e_nrdy [MAXC];
    bit       e_win  [MAXC];
    bit [5:0] e_sid  [MAXC];
    bit       e_new  [MAXC];
    bit       e_en   [MAXC];

    // table and statistics model
    bit [31:0] m_tag [64];
    bit        m_val [64];
    int        m_pkts = 0, m_new = 0, m_runt = 0;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 1'b0;

    int       obs_load, obs_eop;
    int       obs_cc[$];
    bit [7:0] obs_cv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [5:0] m_index(input logic [31:0] k);
        logic [5:0] r;
        r = '0;
        for (int g = 0; g < 6; g++) r ^= 6'((k >> (6 * g)) & 32'h3F);
        return r;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_load = -1;
        obs_eop  = -1;
        obs_cc.delete();
        obs_cv.delete();
    endtask

    task automatic put(input int c, input bit [7:0] d, input bit sop, input bit eopf);
        drv_vld[c] = 1'b1;
        drv_dat[c] = d;
        drv_sop[c] = sop;
        drv_eop[c] = eopf;
    endtask

    // Plans one packet starting next cycle and waits until it has played out.
    task automatic send_pkt(input logic [7:0] b[$], input bit en, input int gap_after,
                            input int gap_len, input int sop_at, input int rst_at);
        int s, n, h, L, R, t, tl, E, endc, lim;
        bit rsted, hit;
        logic [31:0] key;
        logic [5:0] ix;
        s = cyc + 1;
        n = b.size();
        rsted = 1'b0;
        lim = (n < KB) ? n : KB;
        for (int i = 0; i < lim; i++) put(s + i, b[i], i == 0, i == n - 1);
        drv_en[s] = en;
        if (n <= KB) begin
            h = s + n - 1;
            for (int c = s + 1; c <= h; c++) e_busy[c] = 1'b1;
            e_runt[h + 1] = 1'b1;
            m_runt++;
            endc = h + 1;
        end else begin
            key = '0;
            for (int i = 0; i < KB; i++) key = (key << 8) | 32'(b[i]);
            ix  = m_index(key);
            hit = m_val[ix] && (m_tag[ix] == key);
            if (!hit) begin
                m_val[ix] = 1'b1;
                m_tag[ix] = key;
            end
            h = s + KB - 1;
            L = h + 2;
            R = L + 1 + LG;
            for (int c = h + 1; c < R; c++) e_nrdy[c] = 1'b1;
            e_load[L] = 1'b1;
            t = R;
            tl = R;
            endc = R;
            for (int j = KB; j < n; j++) begin
                if (j == rst_at) begin
                    drv_rst[t] = 1'b1;
                    rsted = 1'b1;
                    // leftover bytes arrive without sop and must be discarded
                    for (int k = j; k < n; k++) put(t + 1 + (k - j), b[k], 1'b0, k == n - 1);
                    endc = t + 1 + (n - j);
                    break;
                end
                if (j == KB) begin
                    for (int c = h + 1; c <= R; c++) put(c, b[j], j == sop_at, j == n - 1);
                end else begin
                    put(t, b[j], j == sop_at, j == n - 1);
                end
                e_cv[t + 1]   = 1'b1;
                e_char[t + 1] = b[j];
                tl = t;
                t = t + 1 + ((j == gap_after) ? gap_len : 0);
            end
            if (rsted) begin
                E = t;
                for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
                m_pkts = 0;
                m_new  = 0;
                m_runt = 0;
            end else begin
                E = tl + 1 + ED;
                for (int c = tl + 1; c <= E; c++) e_nrdy[c] = 1'b1;
                e_eop[E] = 1'b1;
                m_pkts++;
                if (!hit) m_new++;
                endc = E;
            end
            for (int c = s + 1; c <= E; c++) e_busy[c] = 1'b1;
            for (int c = L; c <= E; c++) begin
                e_win[c] = 1'b1;
                e_sid[c] = ix;
                e_new[c] = !hit;
                e_en[c]  = en;
            end
        end
        wait_cyc(endc);
    endtask

    // driver
    initial begin
        sif.in_vld  = 1'b0;
        sif.in_sop  = 1'b0;
        sif.in_eop  = 1'b0;
        sif.in_data = 8'h00;
        forever begin
            @(negedge clk);
            if (cyc < MAXC) begin
                rst_n       = !drv_rst[cyc];
                sif.in_vld  = drv_vld[cyc];
                sif.in_sop  = drv_sop[cyc];
                sif.in_eop  = drv_eop[cyc];
                sif.in_data = drv_dat[cyc];
                cfg_enable  = drv_en[cyc];
            end
        end
    end

    // per-cycle compare against the plan
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && cyc < MAXC) begin
                chk("load_state", load_state, e_load[cyc]);
                chk("eop", eop, e_eop[cyc]);
                chk("runt_drop", runt_drop, e_runt[cyc]);
                chk("char_in_vld", char_in_vld, e_cv[cyc]);
                if (e_cv[cyc]) chk("char_in", char_in, e_char[cyc]);
                chk("busy", busy, e_busy[cyc]);
                chk("in_rdy", sif.in_rdy, !e_nrdy[cyc]);
                if (e_win[cyc]) begin
                    chk("stream_id", stream_id, e_sid[cyc]);
                    chk("new_stream_id", new_stream_id, e_new[cyc]);
                    chk("enable", enable, e_en[cyc]);
                end
                if (load_state) obs_load = cyc;
                if (eop) obs_eop = cyc;
                if (char_in_vld) begin
                    obs_cc.push_back(cyc);
                    obs_cv.push_back(char_in);
                end
            end
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: run exceeded %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pk[$];
        for (int i = 0; i < 5; i++) drv_rst[i] = 1'b1;
        @(negedge clk);
        wait_cyc(6);
        chk_on = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_in_rdy", sif.in_rdy, 1);
        chk("rst_char_vld", char_in_vld, 0);

        // key 1 + "abc": miss at index 1
        clear_obs();
        pk = {8'h00, 8'h00, 8'h00, 8'h01, 8'h61, 8'h62, 8'h63};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        chk("p1_sid", stream_id, 1);
        chk("p1_new", new_stream_id, 1);
        chk("p1_nchar", obs_cv.size(), 3);
        chk("p1_c0", obs_cv[0], 8'h61);
        chk("p1_c2", obs_cv[2], 8'h63);
        chk("p1_load_to_char", obs_cc[0] - obs_load, 4);
        chk("p1_char_to_eop", obs_eop - obs_cc[2], 4);
        wait_cyc(cyc + 3);

        // same key + "d": hit
        clear_obs();
        pk = {8'h00, 8'h00, 8'h00, 8'h01, 8'h64};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        chk("p2_sid", stream_id, 1);
        chk("p2_new", new_stream_id, 0);
        chk("p2_c0", obs_cv[0], 8'h64);
        wait_cyc(cyc + 3);

        // 0x40 lands on index 1 with a different tag: evicts key 1
        pk = {8'h00, 8'h00, 8'h00, 8'h40, 8'h65};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        chk("p3_sid", stream_id, 1);
        chk("p3_new", new_stream_id, 1);
        wait_cyc(cyc + 3);

        // 0x41 folds to index 0
        pk = {8'h00, 8'h00, 8'h00, 8'h41, 8'h66};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        chk("p3b_sid", stream_id, 0);
        chk("p3b_new", new_stream_id, 1);
        wait_cyc(cyc + 3);

        // key 1 again: was evicted
        pk = {8'h00, 8'h00, 8'h00, 8'h01, 8'h67};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        chk("p4_sid", stream_id, 1);
        chk("p4_new", new_stream_id, 1);
        wait_cyc(cyc + 3);

        // runt: eop on third header byte
        clear_obs();
        pk = {8'h00, 8'h00, 8'h07};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        wait_cyc(cyc + 1);
        chk("runt_no_load", obs_load, -1);
        chk("runt_no_eop", obs_eop, -1);
        chk("runt_busy", busy, 0);
        wait_cyc(cyc + 2);

        // runt: sop and eop on one byte
        pk = {8'h09};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        wait_cyc(cyc + 3);

        // normal packet after runts, sop flag inside payload is just data
        clear_obs();
        pk = {8'h12, 8'h34, 8'h56, 8'h78, 8'h68, 8'h69};
        send_pkt(pk, 1'b1, -1, 0, 5, -1);
        chk("p6_sid", stream_id, 59);
        chk("p6_new", new_stream_id, 1);
        chk("p6_nchar", obs_cv.size(), 2);
        chk("p6_c1", obs_cv[1], 8'h69);
        wait_cyc(cyc + 3);

        // "wxyz", two bubbles between x and y, enable off
        clear_obs();
        pk = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h77, 8'h78, 8'h79, 8'h7A};
        send_pkt(pk, 1'b0, 5, 2, -1, -1);
        chk("p7_sid", stream_id, 37);
        chk("p7_enable", enable, 0);
        chk("p7_bubble", obs_cc[2] - obs_cc[1], 3);
        chk("p7_contig", obs_cc[1] - obs_cc[0], 1);
        wait_cyc(cyc + 3);

`ifdef DPI_STATS_EN
        chk("stat_pkts", stat_pkts, m_pkts);
        chk("stat_new", stat_new, m_new);
        chk("stat_runt", stat_runt, m_runt);
        chk("stat_pkts_lit", stat_pkts, 7);
        chk("stat_runt_lit", stat_runt, 2);
`endif

        // reset during payload, trailing bytes discarded
        clear_obs();
        pk = {8'h00, 8'h00, 8'h00, 8'h01, 8'h70, 8'h71, 8'h72, 8'h73};
        send_pkt(pk, 1'b1, -1, 0, -1, 6);
        chk("rst_no_eop", obs_eop, -1);
        chk("rst_nchar", obs_cv.size(), 2);
        wait_cyc(cyc + 3);

        // key 1 after reset: table was cleared
        pk = {8'h00, 8'h00, 8'h00, 8'h01, 8'h74};
        send_pkt(pk, 1'b1, -1, 0, -1, -1);
        chk("p9_sid", stream_id, 1);
        chk("p9_new", new_stream_id, 1);
        wait_cyc(cyc + 3);

`ifdef DPI_STATS_EN
        chk("stat_pkts_post_rst", stat_pkts, m_pkts);
        chk("stat_new_post_rst", stat_new, m_new);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
